// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame assembler and its wrapper.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int n_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles, flags expiry, never wraps.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q, timer_d;

  // A clear in the expiry cycle (byte accepted) suppresses the expiry.
  assign expire = enable && !clear && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_d = timer_q;
    if (clear || expire) begin
      timer_d = '0;
    end else if (enable) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler: hunts for a sync byte, shifts in N_BYTES payload bytes
// MSB-first and presents the frame over a valid/ready handshake.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         NET_INPUTS     = 784,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 12000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [NET_INPUTS-1:0] m_frame_data,
  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic                  timeout_err,
  output logic                  sync_err
);

  localparam int N_BYTES = n_bytes(NET_INPUTS);
  localparam int CNT_W   = $clog2(N_BYTES + 1);

  frame_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NET_INPUTS-1:0] sr_q, sr_d, sr_next;
  logic [NET_INPUTS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  tready_q, tready_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  sync_err_q, sync_err_d;
  logic                  accept;
  logic                  expire;

  assign accept = s_axis_tvalid && tready_q;

  // Shifting within NET_INPUTS bits drops the padding bits of the first byte.
  assign sr_next = (sr_q << 8) | NET_INPUTS'(s_axis_tdata);

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept || (state_q != S_LOAD)),
    .enable(state_q == S_LOAD),
    .expire(expire)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sr_d          = sr_q;
    data_d        = data_q;
    sync_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    unique case (state_q)
      S_HUNT: begin
        if (accept) begin
          if (s_axis_tdata == SYNC_BYTE) begin
            state_d = S_LOAD;
            cnt_d   = '0;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          sr_d  = sr_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_BYTES - 1)) begin
            state_d = S_HOLD;
            data_d  = sr_next;
            cnt_d   = '0;
          end
        end else if (expire) begin
          state_d       = S_HUNT;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (m_frame_ready) begin
          state_d = S_HUNT;
        end
      end
      default: begin
        state_d = S_HUNT;
        cnt_d   = '0;
      end
    endcase
    // Deriving both from the next state keeps tready and valid mutually exclusive.
    valid_d  = (state_d == S_HOLD);
    tready_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      cnt_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      tready_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      tready_q      <= tready_d;
      timeout_err_q <= timeout_err_d;
      sync_err_q    <= sync_err_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign s_axis_tready = tready_q;
  assign m_frame_data  = data_q;
  assign m_frame_valid = valid_q;
  assign timeout_err   = timeout_err_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with NET_INPUTS=12 and TIMEOUT_CYCLES=16.
module tb_uart_frame_rx;

  localparam int NET_INPUTS     = 12;
  localparam int TIMEOUT_CYCLES = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [7:0]            s_axis_tdata = 8'h00;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic [NET_INPUTS-1:0] m_frame_data;
  logic                  m_frame_valid;
  logic                  m_frame_ready = 1'b1;
  logic                  timeout_err;
  logic                  sync_err;

  int checks = 0;
  int failures = 0;

  int sync_cnt = 0;
  int to_cnt = 0;
  int frame_cnt = 0;
  int both_cnt = 0;

  int base_sync, base_to, base_frame;
  int bad;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .NET_INPUTS    (NET_INPUTS),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_frame_data (m_frame_data),
    .m_frame_valid(m_frame_valid),
    .m_frame_ready(m_frame_ready),
    .timeout_err  (timeout_err),
    .sync_err     (sync_err)
  );

  always @(negedge clk) begin
    if (sync_err) sync_cnt++;
    if (timeout_err) to_cnt++;
    if (m_frame_valid && m_frame_ready) frame_cnt++;
    if (m_frame_valid && s_axis_tready) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers a byte in the current cycle and returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (s_axis_tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    chk("send_accept_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic snap();
    base_sync  = sync_cnt;
    base_to    = to_cnt;
    base_frame = frame_cnt;
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_valid", {31'd0, m_frame_valid}, 32'd0);
    chk("rst_data", 32'(m_frame_data), 32'd0);
    chk("rst_errs", {30'd0, timeout_err, sync_err}, 32'd0);
    rst = 1'b0;
    chk("tready_low_at_release", {31'd0, s_axis_tready}, 32'd0);
    cyc(1);
    chk("tready_rises", {31'd0, s_axis_tready}, 32'd1);

    // Basic frame
    snap();
    send(8'hA5); send(8'hAB); send(8'hCD);
    chk("basic_valid_latency", {31'd0, m_frame_valid}, 32'd1);
    chk("basic_data", 32'(m_frame_data), 32'h0BCD);
    chk("basic_tready_low", {31'd0, s_axis_tready}, 32'd0);
    cyc(3);
    chk("basic_frames", 32'(frame_cnt - base_frame), 32'd1);
    chk("basic_no_sync_err", 32'(sync_cnt - base_sync), 32'd0);
    chk("basic_no_timeout", 32'(to_cnt - base_to), 32'd0);

    // Hunt
    snap();
    send(8'h3C);
    chk("hunt_sync_err_pulse", {31'd0, sync_err}, 32'd1);
    send(8'h7E); send(8'hA5); send(8'h12); send(8'h34);
    chk("hunt_valid", {31'd0, m_frame_valid}, 32'd1);
    chk("hunt_data", 32'(m_frame_data), 32'h0234);
    cyc(3);
    chk("hunt_sync_errs", 32'(sync_cnt - base_sync), 32'd2);
    chk("hunt_frames", 32'(frame_cnt - base_frame), 32'd1);

    // Timeout
    snap();
    send(8'hA5); send(8'h11);
    cyc(15);
    chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
    cyc(1);
    chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    chk("to_data_kept", 32'(m_frame_data), 32'h0234);
    cyc(3);
    chk("to_once", 32'(to_cnt - base_to), 32'd1);
    chk("to_no_frame", 32'(frame_cnt - base_frame), 32'd0);
    send(8'hA5); send(8'h22); send(8'h33);
    chk("to_next_frame", 32'(m_frame_data), 32'h0233);
    cyc(3);

    // Timeout race: byte arrives in the expiry cycle
    snap();
    send(8'hA5); send(8'h11);
    cyc(15);
    send(8'h12);
    chk("race_valid", {31'd0, m_frame_valid}, 32'd1);
    chk("race_data", 32'(m_frame_data), 32'h0112);
    cyc(20);
    chk("race_no_timeout", 32'(to_cnt - base_to), 32'd0);

    // Backpressure
    snap();
    m_frame_ready = 1'b0;
    send(8'hA5); send(8'hFF); send(8'h01);
    s_axis_tdata  = 8'hA5;
    s_axis_tvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (s_axis_tready !== 1'b0 || m_frame_valid !== 1'b1 || m_frame_data !== 12'hF01) bad++;
    end
    chk("bp_hold_stable", 32'(bad), 32'd0);
    chk("bp_data", 32'(m_frame_data), 32'h0F01);
    m_frame_ready = 1'b1;
    cyc(1);
    chk("bp_valid_drop", {31'd0, m_frame_valid}, 32'd0);
    chk("bp_tready_back", {31'd0, s_axis_tready}, 32'd1);
    cyc(1);
    s_axis_tvalid = 1'b0;
    send(8'h4F); send(8'h5E);
    chk("bp_pending_sync_used", 32'(m_frame_data), 32'h0F5E);
    cyc(3);
    chk("bp_no_sync_err", 32'(sync_cnt - base_sync), 32'd0);
    chk("bp_frames", 32'(frame_cnt - base_frame), 32'd2);

    // Reset mid-frame
    snap();
    send(8'hA5); send(8'h55);
    rst = 1'b1;
    cyc(1);
    chk("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("midrst_valid", {31'd0, m_frame_valid}, 32'd0);
    chk("midrst_data", 32'(m_frame_data), 32'd0);
    chk("midrst_errs", {30'd0, timeout_err, sync_err}, 32'd0);
    rst = 1'b0;
    cyc(20);
    chk("midrst_no_pulses", 32'((to_cnt - base_to) + (sync_cnt - base_sync)), 32'd0);
    send(8'hA5); send(8'h66); send(8'h77);
    chk("midrst_frame", 32'(m_frame_data), 32'h0677);
    cyc(3);
    chk("midrst_frames", 32'(frame_cnt - base_frame), 32'd1);

    chk("tready_valid_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
